t06_lcd8080_rx: RTL
===================

Name: t06_lcd8080_rx

Overview:
- Receive-side endpoint of the team's write-only 8080-style parallel LCD bus (d[7:0], wr, dcx) that t06_assembly drives toward the TFT.
- Synchronizes the bus into the local clock domain and decodes the ILI9341-style command subset: CASET, PASET, RAMWR, SWRESET.
- Emits one pixel (x, y, RGB565) per two data bytes.
- Used as an on-chip display emulator and as the checker front end in system benches.

Parameters:
- X_W, 9, column address width; 16-bit CASET values are truncated to X_W bits.
- Y_W, 9, row address width; 16-bit PASET values are truncated to Y_W bits.
- SYNC_STAGES, 2, flip-flop stages in the bus synchronizer (minimum 2).

Ports:
- clk  in  1  system clock.
- nrst  in  1  asynchronous active-low reset.
- enable  in  1  when low, decoded bus strobes are dropped; synchronizer keeps running.
- d_in  in  8  bus data.
- wr_in  in  1  write strobe; a byte is accepted on its rising edge.
- dcx_in  in  1  0 = command byte, 1 = data/parameter byte.
- px_valid  out  1  one-cycle pixel strobe.
- px_x  out  X_W  pixel column.
- px_y  out  Y_W  pixel row.
- px_color  out  16  RGB565, first byte = [15:8].
- frame_done  out  1  one-cycle pulse when the last pixel of the window is emitted.
- busy  out  1  high while in RAMWR streaming.

Behaviour:
- Reset: all outputs 0; windows SC=0, EC=all ones (X_W), SP=0, EP=all ones (Y_W); FSM in IDLE; synchronizer flops 0.
- Synchronization:
  - wr_in, dcx_in and d_in all pass through identical SYNC_STAGES flop chains, so they stay aligned.
  - A byte strobe fires in the cycle the synchronized wr shows a 0->1 transition; synced d and dcx are sampled in that cycle.
  - Bus requirement: wr low ≥ SYNC_STAGES+1 clk, wr high ≥ SYNC_STAGES+1 clk, d/dcx stable from wr falling edge to wr rising edge + SYNC_STAGES clk.
- A strobe with enable=0 is discarded completely; FSM and counters do not change.
- Any command byte (dcx=0) aborts the current sequence:
  - partial parameters are discarded; committed window registers keep their old values;
  - a pending half-pixel is discarded;
  - the FSM then decodes the new command.
- FSM states and transitions:
  - IDLE:
    - 0x2A -> CASET_P.
    - 0x2B -> PASET_P.
    - 0x2C -> RAMWR; x=SC, y=SP.
    - 0x01 -> window registers reset to their reset values; stay IDLE.
    - Any other command is ignored.
    - Data bytes in IDLE are ignored.
  - CASET_P / PASET_P: collect 4 parameter bytes (start hi, start lo, end hi, end lo). On the 4th byte, commit start and end together, truncated to the address width, then go to IDLE.
  - RAMWR:
    - Even data byte: latched as high byte.
    - Odd data byte: completes the pixel. Next cycle: px_valid=1 with the current x, y and {hi,lo}. Latency is 1 clk after the second strobe.
    - Address advance after each pixel:
      - if x==EC: x=SC and y advances;
      - y advance: if y==EP, y=SP and frame_done pulses with that px_valid; else y+1;
      - otherwise x+1, wrapping modulo 2^X_W (this also covers SC>EC).
    - busy=1 throughout RAMWR; it drops the cycle after the command byte that exits RAMWR.
- Reset mid-operation returns everything to reset values immediately; no pixel is emitted.

Optional Feature:
- Macro: T06_LCDRX_MADCTL_EN.
- Defined:
  - Command 0x36 takes 1 parameter byte.
  - Bit 3 (BGR) is stored, reset value 0.
  - While BGR=1, px_color = {color[4:0], color[10:5], color[15:11]}, i.e. R and B swapped.
  - 0x01 clears BGR.
- Undefined: 0x36 is an unknown command (ignored), and its parameter is ignored as an IDLE data byte.

Decomposition:
- Package t06_lcd_pkg:
  - command constants CMD_SWRESET=8'h01, CMD_CASET=8'h2A, CMD_PASET=8'h2B, CMD_RAMWR=8'h2C, CMD_MADCTL=8'h36;
  - FSM state enum (IDLE, CASET_P, PASET_P, RAMWR, MADCTL_P);
  - RGB565 field positions.
- Sub-module t06_bus_sync: parameterized synchronizer for {wr, dcx, d} plus wr rising-edge detector; outputs strobe, dcx_s, d_s.

Test Plan:
- Reset, then RAMWR with bytes F8,00 -> one px_valid with x=0, y=0, color=16'hF800; busy=1.
- CASET 00,0A,00,0B; PASET 00,05,00,06; RAMWR plus 4 pixels -> coordinates (10,5),(11,5),(10,6),(11,6); frame_done on the 4th pixel; 5th pixel at (10,5).
- CASET 00,14 then command 0x2C (aborted) -> window unchanged (SC=0, EC=511); RAMWR starts at x=0.
- RAMWR, byte 12, then command 0x00, then RAMWR 34,56 -> single pixel 16'h3456; the 12 is discarded.
- enable=0 during RAMWR byte pair -> no px_valid; the next pair after enable=1 yields pixel at the unchanged x.
- With T06_LCDRX_MADCTL_EN: 0x36 param 08, then RAMWR F8,00 -> px_color=16'h001F; after 0x01, the same pair gives F800.

Source files
------------

// File: rtl/t06_lcd_pkg.sv
// rtl/t06_lcd_pkg.sv - command codes, FSM states and RGB565 field helpers for the 8080 bus receiver
package t06_lcd_pkg;

  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_PASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;
  localparam logic [7:0] CMD_MADCTL  = 8'h36;

  typedef enum logic [2:0] {
    IDLE,
    CASET_P,
    PASET_P,
    RAMWR,
    MADCTL_P
  } lcd_state_e;

  localparam int RGB_R_MSB = 15;
  localparam int RGB_R_LSB = 11;
  localparam int RGB_G_MSB = 10;
  localparam int RGB_G_LSB = 5;
  localparam int RGB_B_MSB = 4;
  localparam int RGB_B_LSB = 0;

  // Exchanges the red and blue fields, leaving green in place.
  function automatic logic [15:0] rgb565_swap_rb(input logic [15:0] c);
    return {c[RGB_B_MSB:RGB_B_LSB], c[RGB_G_MSB:RGB_G_LSB], c[RGB_R_MSB:RGB_R_LSB]};
  endfunction

endpackage

// File: rtl/t06_bus_sync.sv
// rtl/t06_bus_sync.sv - aligned flop chains for {wr, dcx, d} plus synchronized wr rising-edge strobe
module t06_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       wr_in,
  input  logic       dcx_in,
  input  logic [7:0] d_in,
  output logic       strobe,
  output logic       dcx_s,
  output logic [7:0] d_s
);

  logic [9:0] sync_q [SYNC_STAGES];
  logic       wr_prev_q;

  // All bus lines share one chain so data and dcx arrive with their strobe.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      wr_prev_q <= 1'b0;
    end else begin
      sync_q[0] <= {wr_in, dcx_in, d_in};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      wr_prev_q <= sync_q[SYNC_STAGES-1][9];
    end
  end

  assign strobe = sync_q[SYNC_STAGES-1][9] & ~wr_prev_q;
  assign dcx_s  = sync_q[SYNC_STAGES-1][8];
  assign d_s    = sync_q[SYNC_STAGES-1][7:0];

endmodule

// File: rtl/t06_lcd8080_rx.sv
// rtl/t06_lcd8080_rx.sv - 8080 LCD bus receiver decoding CASET/PASET/RAMWR/SWRESET into pixels; T06_LCDRX_MADCTL_EN adds BGR swap
module t06_lcd8080_rx
  import t06_lcd_pkg::*;
#(
  parameter int X_W         = 9,
  parameter int Y_W         = 9,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           nrst,
  input  logic           enable,
  input  logic [7:0]     d_in,
  input  logic           wr_in,
  input  logic           dcx_in,
  output logic           px_valid,
  output logic [X_W-1:0] px_x,
  output logic [Y_W-1:0] px_y,
  output logic [15:0]    px_color,
  output logic           frame_done,
  output logic           busy
);

  localparam logic [X_W-1:0] X_ONE = 1;
  localparam logic [Y_W-1:0] Y_ONE = 1;

  logic       strobe;
  logic       dcx_s;
  logic [7:0] d_s;

  t06_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .nrst   (nrst),
    .wr_in  (wr_in),
    .dcx_in (dcx_in),
    .d_in   (d_in),
    .strobe (strobe),
    .dcx_s  (dcx_s),
    .d_s    (d_s)
  );

  lcd_state_e     state_q;
  logic [1:0]     pcnt_q;
  logic [23:0]    pbuf_q;
  logic [X_W-1:0] sc_q, ec_q, x_q, px_x_q;
  logic [Y_W-1:0] sp_q, ep_q, y_q, px_y_q;
  logic [7:0]     hi_q;
  logic           half_q;
  logic           px_valid_q, frame_done_q;
  logic [15:0]    px_color_q;

  logic           stb;
  logic [15:0]    start16, end16, pixel16, color_d;

  assign stb     = strobe & enable;
  assign start16 = pbuf_q[23:8];
  assign end16   = {pbuf_q[7:0], d_s};
  assign pixel16 = {hi_q, d_s};

`ifdef T06_LCDRX_MADCTL_EN
  logic bgr_q;
  assign color_d = bgr_q ? rgb565_swap_rb(pixel16) : pixel16;
`else
  assign color_d = pixel16;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= IDLE;
      pcnt_q       <= 2'd0;
      pbuf_q       <= '0;
      sc_q         <= '0;
      ec_q         <= '1;
      sp_q         <= '0;
      ep_q         <= '1;
      x_q          <= '0;
      y_q          <= '0;
      hi_q         <= '0;
      half_q       <= 1'b0;
      px_valid_q   <= 1'b0;
      frame_done_q <= 1'b0;
      px_x_q       <= '0;
      px_y_q       <= '0;
      px_color_q   <= '0;
`ifdef T06_LCDRX_MADCTL_EN
      bgr_q        <= 1'b0;
`endif
    end else begin
      px_valid_q   <= 1'b0;
      frame_done_q <= 1'b0;
      if (stb) begin
        if (!dcx_s) begin
          // A command always abandons partial parameters and half pixels.
          pcnt_q <= 2'd0;
          half_q <= 1'b0;
          case (d_s)
            CMD_CASET: state_q <= CASET_P;
            CMD_PASET: state_q <= PASET_P;
            CMD_RAMWR: begin
              state_q <= RAMWR;
              x_q     <= sc_q;
              y_q     <= sp_q;
            end
            CMD_SWRESET: begin
              state_q <= IDLE;
              sc_q    <= '0;
              ec_q    <= '1;
              sp_q    <= '0;
              ep_q    <= '1;
`ifdef T06_LCDRX_MADCTL_EN
              bgr_q   <= 1'b0;
`endif
            end
`ifdef T06_LCDRX_MADCTL_EN
            CMD_MADCTL: state_q <= MADCTL_P;
`endif
            default: state_q <= IDLE;
          endcase
        end else begin
          case (state_q)
            CASET_P, PASET_P: begin
              pbuf_q <= {pbuf_q[15:0], d_s};
              pcnt_q <= pcnt_q + 2'd1;
              if (pcnt_q == 2'd3) begin
                if (state_q == CASET_P) begin
                  sc_q <= start16[X_W-1:0];
                  ec_q <= end16[X_W-1:0];
                end else begin
                  sp_q <= start16[Y_W-1:0];
                  ep_q <= end16[Y_W-1:0];
                end
                state_q <= IDLE;
              end
            end
            RAMWR: begin
              if (!half_q) begin
                hi_q   <= d_s;
                half_q <= 1'b1;
              end else begin
                half_q       <= 1'b0;
                px_valid_q   <= 1'b1;
                px_x_q       <= x_q;
                px_y_q       <= y_q;
                px_color_q   <= color_d;
                frame_done_q <= (x_q == ec_q) && (y_q == ep_q);
                if (x_q == ec_q) begin
                  x_q <= sc_q;
                  y_q <= (y_q == ep_q) ? sp_q : y_q + Y_ONE;
                end else begin
                  x_q <= x_q + X_ONE;
                end
              end
            end
            MADCTL_P: begin
`ifdef T06_LCDRX_MADCTL_EN
              bgr_q <= d_s[3];
`endif
              state_q <= IDLE;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign px_valid   = px_valid_q;
  assign px_x       = px_x_q;
  assign px_y       = px_y_q;
  assign px_color   = px_color_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q == RAMWR);

endmodule
